completion_collector: RTL and testbench

COMPLETION_COLLECTOR -- requirements
Module: completion_collector

---
 rtl/completion_collector_pkg.sv | 21 ++
 rtl/completion_collector_cpl_fifo.sv | 56 +++++
 rtl/completion_collector.sv | 148 ++++++++++++++
 tb/tb_completion_collector.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/completion_collector_pkg.sv
// Shared definitions for the completion collector: default sizing, the
// completion record type and the round-robin index helper.
package completion_collector_pkg;

    localparam int DEF_INST_ID_BITS = 6;
    localparam int DEF_FU_COUNT     = 4;
    localparam int DEF_FUC_BITS     = 2;
    localparam int DEF_FIFO_DEPTH   = 4;

    // One completion as seen by the ROB: which instruction, which unit.
    typedef struct packed {
        logic [DEF_INST_ID_BITS-1:0] inst_id;
        logic [DEF_FUC_BITS-1:0]     fu;
    } cpl_entry_t;

    // Wrap an index that may run at most one lap past the FU count.
    function automatic int rr_wrap(input int idx, input int count);
        return (idx >= count) ? (idx - count) : idx;
    endfunction

endpackage

// File: rtl/completion_collector_cpl_fifo.sv
// Per-FU completion queue. Pointers carry one extra wrap bit so that full and
// empty are distinguishable without a separate occupancy register. Pushes to a
// full queue are ignored here; the parent flags them as overflow. Flush wins
// over a same-cycle push or pop.
module cpl_fifo
    import completion_collector_pkg::*;
#(
    parameter int  WIDTH = DEF_INST_ID_BITS,
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer update; reset and flush both return the queue to empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/completion_collector.sv
// Collects completion pulses from several functional units into per-FU
// queues and offers them one at a time to the ROB in round-robin order.
// Once an offer is stalled its grant is locked so the ROB sees a stable
// ID/FU pair until it accepts. All outputs derive from registered state, so a
// pushed entry is never offered in the cycle it arrives.
module completion_collector
    import completion_collector_pkg::*;
#(
    parameter int  INST_ID_BITS = DEF_INST_ID_BITS,
    parameter int  FU_COUNT     = DEF_FU_COUNT,
    parameter int  FUC_BITS     = DEF_FUC_BITS,
    parameter int  FIFO_DEPTH   = DEF_FIFO_DEPTH,
    localparam int PCW          = $clog2(FU_COUNT*FIFO_DEPTH+1),
    localparam int CW           = $clog2(FIFO_DEPTH)+1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FU_COUNT-1:0]                  fu_out_inst_valid,
    input  logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_out_inst_ids,
    output logic [FU_COUNT-1:0]                  fu_cpl_ready,
    input  logic                                 flush,
    output logic                                 cpl_valid,
    input  logic                                 cpl_ready,
    output logic [INST_ID_BITS-1:0]              cpl_inst_id,
    output logic [FUC_BITS-1:0]                  cpl_fu,
    output logic [PCW-1:0]                       pending_count,
    output logic                                 overflow_err
);

    logic [FU_COUNT-1:0]     fifo_full;
    logic [FU_COUNT-1:0]     fifo_empty;
    logic [FU_COUNT-1:0]     fifo_pop;
    logic [INST_ID_BITS-1:0] fifo_head  [FU_COUNT];
    logic [CW-1:0]           fifo_count [FU_COUNT];

    logic [FUC_BITS-1:0]     rr_ptr;
    logic [FUC_BITS-1:0]     lock_fu;
    logic                    lock;
    logic [FUC_BITS-1:0]     search_fu;
    logic                    search_hit;
    logic [FUC_BITS-1:0]     grant_fu;
    logic                    accept;
    logic [PCW-1:0]          push_total;
    logic [FU_COUNT-1:0]     push_drop;
    logic [PCW-1:0]          count_sum;

    for (genvar i = 0; i < FU_COUNT; i++) begin : g_fifo
        assign fifo_pop[i] = accept && (int'(grant_fu) == i);

        cpl_fifo #(
            .WIDTH (INST_ID_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (fu_out_inst_valid[i]),
            .push_data (fu_out_inst_ids[i]),
            .pop       (fifo_pop[i]),
            .flush     (flush),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .head      (fifo_head[i]),
            .count     (fifo_count[i])
        );
    end

    // Ready reflects the registered full flag only; a pop this cycle does
    // not reopen the slot until the next cycle.
    assign fu_cpl_ready = ~fifo_full;

    // First non-empty queue at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx        = 0;
        search_hit = 1'b0;
        search_fu  = '0;
        for (int off = 0; off < FU_COUNT; off++) begin
            idx = rr_wrap(int'(rr_ptr) + off, FU_COUNT);
            if (!search_hit && !fifo_empty[idx]) begin
                search_hit = 1'b1;
                search_fu  = FUC_BITS'(idx);
            end
        end
    end

    // A locked queue cannot drain behind our back (only the grant pops), so
    // the lock always points at a non-empty queue.
    assign grant_fu    = lock ? lock_fu : search_fu;
    assign cpl_valid   = search_hit;
    assign cpl_fu      = grant_fu;
    assign cpl_inst_id = fifo_head[grant_fu];
    assign accept      = cpl_valid && cpl_ready;

    // Count the pushes that land and spot the ones that hit a full queue.
    always_comb begin
        push_total = '0;
        push_drop  = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            if (fu_out_inst_valid[i]) begin
                if (fifo_full[i]) push_drop[i] = 1'b1;
                else              push_total   = push_total + PCW'(1);
            end
        end
    end

    // Arbitration state and the running occupancy total.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr        <= '0;
            lock          <= 1'b0;
            lock_fu       <= '0;
            pending_count <= '0;
        end else if (flush) begin
            rr_ptr        <= '0;
            lock          <= 1'b0;
            pending_count <= '0;
        end else begin
            pending_count <= pending_count + push_total - PCW'(accept);
            if (accept) begin
                lock   <= 1'b0;
                rr_ptr <= FUC_BITS'(rr_wrap(int'(grant_fu) + 1, FU_COUNT));
            end else if (cpl_valid) begin
                lock    <= 1'b1;
                lock_fu <= grant_fu;
            end
        end
    end

    // Sticky overflow; a dropped completion is lost work, so only reset
    // clears it and flush leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            overflow_err <= 1'b0;
        else if (|push_drop) overflow_err <= 1'b1;
    end

    // Sum of the per-queue occupancies, used to cross-check pending_count.
    always_comb begin
        count_sum = '0;
        for (int i = 0; i < FU_COUNT; i++) begin
            count_sum = count_sum + PCW'(fifo_count[i]);
        end
    end

    pending_matches_queues: assert property (
        @(posedge clk) disable iff (!rst) pending_count == count_sum
    );

endmodule

// File: tb/tb_completion_collector.sv
module tb_completion_collector;
    import completion_collector_pkg::*;

    localparam int IW    = DEF_INST_ID_BITS;
    localparam int NFU   = DEF_FU_COUNT;
    localparam int FB    = DEF_FUC_BITS;
    localparam int DEPTH = DEF_FIFO_DEPTH;
    localparam int PCW   = $clog2(NFU*DEPTH+1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NFU-1:0]           fu_out_inst_valid = '0;
    logic [NFU-1:0][IW-1:0]   fu_out_inst_ids = '0;
    logic [NFU-1:0]           fu_cpl_ready;
    logic                     flush = 1'b0;
    logic                     cpl_valid;
    logic                     cpl_ready = 1'b0;
    logic [IW-1:0]            cpl_inst_id;
    logic [FB-1:0]            cpl_fu;
    logic [PCW-1:0]           pending_count;
    logic                     overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: one queue per FU plus arbitration bookkeeping
    logic [IW-1:0] mq [NFU][$];
    int            m_rr;
    bit            m_locked;
    int            m_lock_fu;
    bit            m_ovf;

    completion_collector #(
        .INST_ID_BITS (IW),
        .FU_COUNT     (NFU),
        .FUC_BITS     (FB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fu_out_inst_valid (fu_out_inst_valid),
        .fu_out_inst_ids   (fu_out_inst_ids),
        .fu_cpl_ready      (fu_cpl_ready),
        .flush             (flush),
        .cpl_valid         (cpl_valid),
        .cpl_ready         (cpl_ready),
        .cpl_inst_id       (cpl_inst_id),
        .cpl_fu            (cpl_fu),
        .pending_count     (pending_count),
        .overflow_err      (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fu_out_inst_valid = '0;
        fu_out_inst_ids   = '0;
        flush             = 1'b0;
    endtask

    task automatic do_flush();
        idle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        cpl_ready = 1'b0;
        #12;
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cpl_valid); end
        n_checks++; if (pending_count !== PCW'(0)) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending_count); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
        n_checks++; if (fu_cpl_ready !== {NFU{1'b1}}) begin n_fail++; $display("FAIL reset_fu_ready: got %b want all ones", fu_cpl_ready); end
        @(posedge clk);
        #1 rst = 1'b1;
        next_cycle();
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", cpl_valid); end
    endtask

    task automatic test_single();
        idle();
        cpl_ready = 1'b1;
        fu_out_inst_valid[2] = 1'b1;
        fu_out_inst_ids[2]   = IW'(8'h15);
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", cpl_valid); end
        next_cycle();
        idle();
        n_checks++; if (cpl_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", cpl_valid); end
        n_checks++; if (cpl_inst_id !== IW'(8'h15)) begin n_fail++; $display("FAIL single_id: got %h want 15", cpl_inst_id); end
        n_checks++; if (cpl_fu !== FB'(2)) begin n_fail++; $display("FAIL single_fu: got %0d want 2", cpl_fu); end
        n_checks++; if (pending_count !== PCW'(1)) begin n_fail++; $display("FAIL single_pending: got %0d want 1", pending_count); end
        next_cycle();
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained_valid: got %b want 0", cpl_valid); end
        n_checks++; if (pending_count !== PCW'(0)) begin n_fail++; $display("FAIL single_drained_pending: got %0d want 0", pending_count); end
    endtask

    task automatic test_all_fus();
        do_flush();
        cpl_ready = 1'b1;
        fu_out_inst_valid = '1;
        for (int i = 0; i < NFU; i++) fu_out_inst_ids[i] = IW'(i + 1);
        next_cycle();
        idle();
        for (int k = 0; k < NFU; k++) begin
            n_checks++; if (cpl_valid !== 1'b1) begin n_fail++; $display("FAIL allfu_valid[%0d]: got %b want 1", k, cpl_valid); end
            n_checks++; if (cpl_fu !== FB'(k)) begin n_fail++; $display("FAIL allfu_fu[%0d]: got %0d want %0d", k, cpl_fu, k); end
            n_checks++; if (cpl_inst_id !== IW'(k + 1)) begin n_fail++; $display("FAIL allfu_id[%0d]: got %h want %h", k, cpl_inst_id, k + 1); end
            n_checks++; if (pending_count !== PCW'(NFU - k)) begin n_fail++; $display("FAIL allfu_pending[%0d]: got %0d want %0d", k, pending_count, NFU - k); end
            next_cycle();
        end
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL allfu_end_valid: got %b want 0", cpl_valid); end
        n_checks++; if (pending_count !== PCW'(0)) begin n_fail++; $display("FAIL allfu_end_pending: got %0d want 0", pending_count); end
    endtask

    task automatic test_lock();
        do_flush();
        cpl_ready = 1'b0;
        fu_out_inst_valid[1] = 1'b1;
        fu_out_inst_ids[1]   = IW'(8'h0A);
        next_cycle();
        idle();
        fu_out_inst_valid[0] = 1'b1;
        fu_out_inst_ids[0]   = IW'(8'h0B);
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (cpl_valid !== 1'b1) begin n_fail++; $display("FAIL lock_valid[%0d]: got %b want 1", c, cpl_valid); end
            n_checks++; if (cpl_fu !== FB'(1)) begin n_fail++; $display("FAIL lock_fu[%0d]: got %0d want 1", c, cpl_fu); end
            n_checks++; if (cpl_inst_id !== IW'(8'h0A)) begin n_fail++; $display("FAIL lock_id[%0d]: got %h want 0a", c, cpl_inst_id); end
            next_cycle();
            idle();
        end
        cpl_ready = 1'b1;
        n_checks++; if (cpl_fu !== FB'(1)) begin n_fail++; $display("FAIL lock_accept_fu: got %0d want 1", cpl_fu); end
        n_checks++; if (pending_count !== PCW'(2)) begin n_fail++; $display("FAIL lock_pending: got %0d want 2", pending_count); end
        next_cycle();
        n_checks++; if (cpl_fu !== FB'(0)) begin n_fail++; $display("FAIL lock_next_fu: got %0d want 0", cpl_fu); end
        n_checks++; if (cpl_inst_id !== IW'(8'h0B)) begin n_fail++; $display("FAIL lock_next_id: got %h want 0b", cpl_inst_id); end
        next_cycle();
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL lock_end_valid: got %b want 0", cpl_valid); end
    endtask

    task automatic test_overflow();
        do_flush();
        cpl_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (fu_cpl_ready[3] !== (k < 4)) begin n_fail++; $display("FAIL ovf_fu_ready[%0d]: got %b want %b", k, fu_cpl_ready[3], (k < 4)); end
            if (k == 4) begin
                n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow_err); end
            end
            fu_out_inst_valid[3] = 1'b1;
            fu_out_inst_ids[3]   = IW'(8'h21 + k);
            next_cycle();
            idle();
        end
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
        n_checks++; if (pending_count !== PCW'(4)) begin n_fail++; $display("FAIL ovf_pending: got %0d want 4", pending_count); end
        cpl_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                n_checks++; if (fu_cpl_ready[3] !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_while_pop: got %b want 0", fu_cpl_ready[3]); end
            end
            n_checks++; if (cpl_fu !== FB'(3)) begin n_fail++; $display("FAIL ovf_drain_fu[%0d]: got %0d want 3", k, cpl_fu); end
            n_checks++; if (cpl_inst_id !== IW'(8'h21 + k)) begin n_fail++; $display("FAIL ovf_drain_id[%0d]: got %h want %h", k, cpl_inst_id, 8'h21 + k); end
            next_cycle();
        end
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_end_valid: got %b want 0", cpl_valid); end
        n_checks++; if (fu_cpl_ready[3] !== 1'b1) begin n_fail++; $display("FAIL ovf_end_ready: got %b want 1", fu_cpl_ready[3]); end
    endtask

    task automatic test_flush_reset();
        idle();
        cpl_ready = 1'b0;
        fu_out_inst_valid = NFU'(4'b0111);
        fu_out_inst_ids[0] = IW'(8'h31);
        fu_out_inst_ids[1] = IW'(8'h32);
        fu_out_inst_ids[2] = IW'(8'h33);
        next_cycle();
        idle();
        n_checks++; if (pending_count !== PCW'(3)) begin n_fail++; $display("FAIL flush_pre_pending: got %0d want 3", pending_count); end
        flush = 1'b1;
        cpl_ready = 1'b1;
        fu_out_inst_valid[0] = 1'b1;
        fu_out_inst_ids[0]   = IW'(8'h3F);
        next_cycle();
        idle();
        cpl_ready = 1'b0;
        n_checks++; if (pending_count !== PCW'(0)) begin n_fail++; $display("FAIL flush_pending: got %0d want 0", pending_count); end
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", cpl_valid); end
        n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL flush_overflow_kept: got %b want 1", overflow_err); end
        next_cycle();
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_dropped: got %b want 0", cpl_valid); end
        fu_out_inst_valid[1] = 1'b1;
        fu_out_inst_ids[1]   = IW'(8'h2C);
        next_cycle();
        idle();
        n_checks++; if (cpl_valid !== 1'b1 || cpl_fu !== FB'(1)) begin n_fail++; $display("FAIL stall_offer: got valid %b fu %0d want 1 fu 1", cpl_valid, cpl_fu); end
        next_cycle();
        #3 rst = 1'b0;
        #1;
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", cpl_valid); end
        n_checks++; if (pending_count !== PCW'(0)) begin n_fail++; $display("FAIL rst_mid_pending: got %0d want 0", pending_count); end
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow: got %b want 0", overflow_err); end
        n_checks++; if (fu_cpl_ready !== {NFU{1'b1}}) begin n_fail++; $display("FAIL rst_mid_fu_ready: got %b want all ones", fu_cpl_ready); end
        @(posedge clk);
        #1 rst = 1'b1;
        cpl_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_valid[%0d]: got %b want 0", c, cpl_valid); end
        end
    endtask

    task automatic test_random(input int ncyc);
        bit             exp_valid;
        int             exp_fu;
        int             total;
        int             idx;
        logic [NFU-1:0] exp_rdy;
        logic [NFU-1:0] acc;
        idle();
        cpl_ready = 1'b0;
        do_flush();
        for (int i = 0; i < NFU; i++) mq[i].delete();
        m_rr = 0; m_locked = 0; m_lock_fu = 0; m_ovf = 0;
        for (int c = 0; c < ncyc; c++) begin
            flush = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NFU; i++) begin
                fu_out_inst_valid[i] = !flush && ($urandom_range(0, 9) < 2);
                fu_out_inst_ids[i]   = IW'($urandom);
            end
            cpl_ready = ($urandom_range(0, 9) < 7);

            exp_valid = 0; exp_fu = 0; total = 0;
            for (int i = 0; i < NFU; i++) begin
                total += mq[i].size();
                exp_rdy[i] = (mq[i].size() < DEPTH);
            end
            if (m_locked) begin
                exp_valid = 1; exp_fu = m_lock_fu;
            end else begin
                for (int off = 0; off < NFU; off++) begin
                    idx = (m_rr + off) % NFU;
                    if (!exp_valid && mq[idx].size() > 0) begin exp_valid = 1; exp_fu = idx; end
                end
            end

            n_checks++; if (cpl_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, cpl_valid, exp_valid); end
            if (exp_valid) begin
                n_checks++; if (cpl_fu !== FB'(exp_fu)) begin n_fail++; $display("FAIL rnd_fu@%0d: got %0d want %0d", c, cpl_fu, exp_fu); end
                n_checks++; if (cpl_inst_id !== mq[exp_fu][0]) begin n_fail++; $display("FAIL rnd_id@%0d: got %h want %h", c, cpl_inst_id, mq[exp_fu][0]); end
            end
            n_checks++; if (pending_count !== PCW'(total)) begin n_fail++; $display("FAIL rnd_pending@%0d: got %0d want %0d", c, pending_count, total); end
            n_checks++; if (fu_cpl_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_fu_ready@%0d: got %b want %b", c, fu_cpl_ready, exp_rdy); end
            n_checks++; if (overflow_err !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, overflow_err, m_ovf); end

            if (flush) begin
                for (int i = 0; i < NFU; i++) mq[i].delete();
                m_rr = 0; m_locked = 0;
            end else begin
                for (int i = 0; i < NFU; i++) begin
                    acc[i] = fu_out_inst_valid[i] && (mq[i].size() < DEPTH);
                    if (fu_out_inst_valid[i] && !acc[i]) m_ovf = 1;
                end
                if (exp_valid && cpl_ready) begin
                    void'(mq[exp_fu].pop_front());
                    m_rr = (exp_fu + 1) % NFU;
                    m_locked = 0;
                end else if (exp_valid) begin
                    m_locked = 1;
                    m_lock_fu = exp_fu;
                end
                for (int i = 0; i < NFU; i++) if (acc[i]) mq[i].push_back(fu_out_inst_ids[i]);
            end
            next_cycle();
        end
        idle();
        cpl_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_fus();
        test_lock();
        test_overflow();
        test_flush_reset();
        test_random(600);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
